// File: rtl/gate_chk_pkg.sv
// Shared types for the gate response checker: gate op codes, FSM states, default widths.
package gate_chk_pkg;

    localparam int unsigned DEF_CNT_W = 8;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NOT  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model of the gate primitives: (op, a, b) -> expected y.
// exp_vld_c is low for the reserved op, which has no defined expected value.
module gate_ref_model
    import gate_chk_pkg::*;
(
    input  op_e  op,
    input  logic a,
    input  logic b,
    output logic exp_c,
    output logic exp_vld_c
);

    always_comb begin
        exp_c     = 1'b0;
        exp_vld_c = 1'b1;
        case (op)
            OP_AND:  exp_c = a & b;
            OP_OR:   exp_c = a | b;
            OP_NOT:  exp_c = ~a;
            OP_NAND: exp_c = ~(a & b);
            OP_NOR:  exp_c = ~(a | b);
            OP_XOR:  exp_c = a ^ b;
            OP_XNOR: exp_c = ~(a ^ b);
            default: exp_vld_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_resp_checker.sv
// Self-checking response checker for a gate under test: counts mismatches over a run
// of NUM_VEC accepted observations. Optional idle timeout via GATE_CHK_TIMEOUT_EN.
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned NUM_VEC = 4,
    parameter int unsigned CNT_W   = DEF_CNT_W,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             a,
    input  logic             b,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic             first_fail_vld
`ifdef GATE_CHK_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    state_e           state_q;
    state_e           state_d;
    op_e              op_q;
    logic [CNT_W-1:0] vec_cnt;

    logic             exp_c;
    logic             exp_vld_c;
    logic             accept_c;
    logic             mismatch_c;
    logic             last_c;
    logic             launch_c;
    logic             to_hit_c;
    logic [CNT_W-1:0] err_nxt_c;

    gate_ref_model u_ref (
        .op        (op_q),
        .a         (a),
        .b         (b),
        .exp_c     (exp_c),
        .exp_vld_c (exp_vld_c)
    );

    assign accept_c   = in_valid & in_ready;
    assign mismatch_c = accept_c & (~exp_vld_c | (y != exp_c));
    assign last_c     = accept_c && (vec_cnt == CNT_W'(NUM_VEC - 1));
    assign launch_c   = start && (state_q != ST_RUN);
    assign err_nxt_c  = (mismatch_c && (err_cnt != '1)) ? err_cnt + CNT_W'(1) : err_cnt;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (last_c || to_hit_c) state_d = ST_DONE;
            ST_DONE: if (start) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered status outputs and run datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            op_q           <= OP_AND;
            vec_cnt        <= '0;
            err_cnt        <= '0;
            first_fail_idx <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            in_ready <= (state_d == ST_RUN);
            busy     <= (state_d == ST_RUN);
            done     <= (state_d == ST_DONE);
            if (launch_c) begin
                op_q           <= op_e'(op_sel);
                vec_cnt        <= '0;
                err_cnt        <= '0;
                first_fail_idx <= '0;
                first_fail_vld <= 1'b0;
                pass           <= 1'b0;
            end else if (accept_c) begin
                vec_cnt <= vec_cnt + CNT_W'(1);
                err_cnt <= err_nxt_c;
                if (mismatch_c && !first_fail_vld) begin
                    first_fail_idx <= vec_cnt;
                    first_fail_vld <= 1'b1;
                end
            end
            // Pass uses the post-update count so the final compare is included
            if (state_q == ST_RUN && state_d == ST_DONE)
                pass <= (err_nxt_c == '0) && !to_hit_c;
        end
    end

`ifdef GATE_CHK_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt;

    assign to_hit_c = (state_q == ST_RUN) && !accept_c && (idle_cnt == IDLE_W'(TIMEOUT - 1));

    // Consecutive no-accept cycles while running
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (launch_c || accept_c || state_q != ST_RUN) idle_cnt <= '0;
            else                                          idle_cnt <= idle_cnt + IDLE_W'(1);
            if (launch_c)      timeout <= 1'b0;
            else if (to_hit_c) timeout <= 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign to_hit_c           = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT == 0);
`endif

endmodule

// File: tb/tb_gate_resp_checker.sv
// Bench for gate_resp_checker: directed plus randomized runs against a truth-table model.
// Timeout checks are compiled in with GATE_CHK_TIMEOUT_EN.
module tb_gate_resp_checker;

    localparam int unsigned NUM_VEC = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       op_sel;
    logic             in_valid;
    logic             in_ready;
    logic             a, b, y;
    logic             busy, done, pass;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] first_fail_idx;
    logic             first_fail_vld;
`ifdef GATE_CHK_TIMEOUT_EN
    logic             timeout;
`endif

    gate_resp_checker #(
        .NUM_VEC (NUM_VEC),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .op_sel         (op_sel),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .a              (a),
        .b              (b),
        .y              (y),
        .busy           (busy),
        .done           (done),
        .pass           (pass),
        .err_cnt        (err_cnt),
        .first_fail_idx (first_fail_idx),
        .first_fail_vld (first_fail_vld)
`ifdef GATE_CHK_TIMEOUT_EN
        ,
        .timeout        (timeout)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state for the current run
    int m_op;
    int m_err;
    int m_idx;
    int m_ffi;
    bit m_ffv;

    // Truth table per op, indexed by {a,b}; reserved op has no valid answer
    function automatic bit ref_ok(input int op, input bit va, input bit vb, input bit vy);
        logic [3:0] tt;
        case (op)
            0: tt = 4'b1000;
            1: tt = 4'b1110;
            2: tt = 4'b0011;
            3: tt = 4'b0111;
            4: tt = 4'b0001;
            5: tt = 4'b0110;
            6: tt = 4'b1001;
            default: return 1'b0;
        endcase
        return tt[{va, vb}] == vy;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_pass"}, 32'(pass), 0);
        check({tag, "_err_cnt"}, 32'(err_cnt), 0);
        check({tag, "_ffi"}, 32'(first_fail_idx), 0);
        check({tag, "_ffv"}, 32'(first_fail_vld), 0);
`ifdef GATE_CHK_TIMEOUT_EN
        check({tag, "_timeout"}, 32'(timeout), 0);
`endif
    endtask

    task automatic do_start(input int op);
        @(negedge clk);
        start  = 1'b1;
        op_sel = 3'(op);
        @(negedge clk);
        start  = 1'b0;
        op_sel = 3'($urandom_range(0, 7));
        m_op  = op;
        m_err = 0;
        m_idx = 0;
        m_ffi = 0;
        m_ffv = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_done", 32'(done), 0);
        check("start_err_cnt", 32'(err_cnt), 0);
        check("start_ffv", 32'(first_fail_vld), 0);
`ifdef GATE_CHK_TIMEOUT_EN
        check("start_timeout", 32'(timeout), 0);
`endif
    endtask

    // Call at a negedge; returns at the negedge after the accept with in_valid low
    task automatic send(input bit va, input bit vb, input bit vy);
        int waited = 0;
        a = va; b = vb; y = vy;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("send_ready_timeout", 32'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (!ref_ok(m_op, va, vb, vy)) begin
            if (m_err < 255) m_err++;
            if (!m_ffv) begin
                m_ffv = 1'b1;
                m_ffi = m_idx;
            end
        end
        m_idx++;
        check("vec_err_cnt", 32'(err_cnt), 32'(m_err));
        check("vec_done", 32'(done), 32'(m_idx == NUM_VEC));
        check("vec_in_ready", 32'(in_ready), 32'(m_idx != NUM_VEC));
    endtask

    task automatic check_final(input string tag);
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_pass"}, 32'(pass), 32'(m_err == 0));
        check({tag, "_err_cnt"}, 32'(err_cnt), 32'(m_err));
        check({tag, "_ffv"}, 32'(first_fail_vld), 32'(m_ffv));
        check({tag, "_ffi"}, 32'(first_fail_idx), 32'(m_ffi));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op_sel = 3'd0;
        in_valid = 1'b0; a = 1'b0; b = 1'b0; y = 1'b0;
        m_op = 0; m_err = 0; m_idx = 0; m_ffi = 0; m_ffv = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Reset mid-run aborts everything
        do_start(0);
        send(1'b1, 1'b1, 1'b1);
        send(1'b0, 1'b1, 1'b1);
        #2 rst = 1'b1;
        #1 check_all_zero("midrun_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("after_rst");

        // AND with correct vectors after reset
        do_start(0);
        for (int i = 0; i < int'(NUM_VEC); i++) begin
            bit va = 1'($urandom);
            bit vb = 1'($urandom);
            send(va, vb, va & vb);
        end
        check_final("and_ok");

        // NAND, all correct
        do_start(3);
        send(1'b0, 1'b0, 1'b1);
        send(1'b0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b1);
        send(1'b1, 1'b1, 1'b0);
        check_final("nand");

        // XOR with two wrong responses at indices 2 and 3
        do_start(5);
        send(1'b0, 1'b0, 1'b0);
        send(1'b0, 1'b1, 1'b1);
        send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b1);
        check_final("xor");

        // NOT with gaps carrying wrong data, then valid held in DONE
        do_start(2);
        for (int i = 0; i < int'(NUM_VEC); i++) begin
            bit va = 1'($urandom);
            a = ~va; b = 1'($urandom); y = va; in_valid = 1'b0;
            @(negedge clk);
            send(va, 1'($urandom), ~va);
        end
        check_final("not");
        in_valid = 1'b1; a = 1'b1; y = 1'b1;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        check_final("not_hold");

        // Reserved op: every accept is a mismatch
        do_start(7);
        for (int i = 0; i < int'(NUM_VEC); i++)
            send(1'($urandom), 1'($urandom), 1'($urandom));
        check_final("rsvd");

        // Random runs with gaps and ignored start pulses
        for (int r = 0; r < 20; r++) begin
            do_start(int'($urandom_range(0, 7)));
            for (int i = 0; i < int'(NUM_VEC); i++) begin
                int gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) begin
                    start  = 1'($urandom);
                    op_sel = 3'($urandom);
                    @(negedge clk);
                    start  = 1'b0;
                end
                begin
                    bit va = 1'($urandom);
                    bit vb = 1'($urandom);
                    bit vy = ($urandom_range(0, 1) == 1) ? 1'($urandom) :
                             (ref_ok(m_op, va, vb, 1'b1) ? 1'b1 : 1'b0);
                    send(va, vb, vy);
                end
            end
            check_final("rand");
        end

`ifdef GATE_CHK_TIMEOUT_EN
        do_start(1);
        send(1'b0, 1'b0, 1'b0);
        repeat (int'(TIMEOUT) - 1) @(negedge clk);
        check("to_early_done", 32'(done), 0);
        check("to_early_timeout", 32'(timeout), 0);
        @(negedge clk);
        check("to_done", 32'(done), 1);
        check("to_timeout", 32'(timeout), 1);
        check("to_pass", 32'(pass), 0);
        check("to_err_cnt", 32'(err_cnt), 0);
        check("to_busy", 32'(busy), 0);
        do_start(1);
        check("to_restart_busy", 32'(busy), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_resp_checker.md
Name: gate_resp_checker

Overview:
- Hardware response checker for the logic-gate primitives: the consuming end of the stimulus/monitor flow.
- Accepts a stream of (a, b, y) observations over a valid/ready handshake and computes the expected y for a gate selected by op_sel.
- Counts mismatches over a fixed-length run, captures the first failing vector index, and reports pass/fail.
- Sits after a gate under test and its stimulus source, replacing printed-monitor inspection with a self-checking result.

Parameters:
NUM_VEC, 4, vectors per run (1..2**CNT_W-1)
CNT_W, 8, width of vector index and error counter
TIMEOUT, 64, idle-cycle limit in RUN (used only with GATE_CHK_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  pulse: begin a run, latch op_sel
op_sel  in  3  0 AND, 1 OR, 2 NOT(a), 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 reserved
in_valid  in  1  observation valid
in_ready  out  1  checker accepting observations
a  in  1  stimulus input a
b  in  1  stimulus input b
y  in  1  observed gate output
busy  out  1  run in progress
done  out  1  run complete (level, held)
pass  out  1  valid when done: 1 = zero mismatches
err_cnt  out  CNT_W  mismatch count, saturating
first_fail_idx  out  CNT_W  index of first mismatching vector
first_fail_vld  out  1  first_fail_idx meaningful
timeout  out  1  only with GATE_CHK_TIMEOUT_EN

Behaviour:
- Reset (asynchronous, rst=1): state IDLE.
  - All outputs 0, including in_ready, busy, done, pass, err_cnt, first_fail_idx, first_fail_vld and timeout.
  - Internal vec_cnt and latched op are 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → RUN next cycle.
  - op_sel latched; vec_cnt, err_cnt, first_fail_* and timeout cleared.
  - pass and done are 0 in RUN.
- RUN:
  - in_ready=1 and busy=1.
  - An accept is in_valid & in_ready. On each accept:
    - Expected value exp is computed from the latched op.
    - If y != exp, err_cnt increments, saturating at all-ones.
    - If first_fail_vld=0, first_fail_idx is set to vec_cnt and first_fail_vld to 1.
    - vec_cnt increments.
  - An accept with vec_cnt == NUM_VEC-1 → DONE next cycle.
  - The final accept's compare is included in err_cnt and pass.
- DONE:
  - in_ready=0, busy=0, done=1.
  - pass = (err_cnt==0), registered on entry to DONE.
  - Counters are held. in_valid is ignored.
  - start=1 → RUN with the same clearing as from IDLE.
- start in RUN is ignored. op_sel changes after start have no effect on the current run.
- op_sel=7 (reserved): every accepted vector counts as a mismatch, so pass=0.
- Latency:
  - Compare result is visible in err_cnt one cycle after the accept.
  - done rises one cycle after the final accept.
- NOT(a) ignores b.
- Reset asserted mid-run aborts the run immediately (asynchronous); no partial result is retained.

Optional Feature:
- Macro: GATE_CHK_TIMEOUT_EN.
- Defined:
  - An idle counter runs in RUN and clears on every accept.
  - Reaching TIMEOUT consecutive cycles without an accept → DONE with timeout=1 and pass=0; err_cnt is unchanged.
  - timeout clears on start or reset.
- Undefined:
  - No timeout port and no counter.
  - RUN waits indefinitely for NUM_VEC accepts.

Decomposition:
- Package gate_chk_pkg:
  - op enum (OP_AND … OP_XNOR, OP_RSVD, 3-bit).
  - FSM state enum.
  - Default CNT_W constant.
- One sub-module, gate_ref_model: purely combinational (op, a, b) → exp. This is the single golden model, reused by benches.

Test Plan:
- Reset mid-RUN after 2 accepts → all outputs 0, state IDLE; a subsequent start with op=AND and 4 correct vectors → pass=1.
- op=NAND (3), vectors (0,0,1),(0,1,1),(1,0,1),(1,1,0) → done=1 one cycle after the 4th accept; pass=1, err_cnt=0, first_fail_vld=0.
- op=XOR (5), vectors (0,0,0),(0,1,1),(1,0,0),(1,1,1) → err_cnt=2, first_fail_idx=2, first_fail_vld=1, pass=0.
- op=NOT (2), in_valid toggled every other cycle, b random, y=~a → only accepted cycles are counted; done after exactly 4 accepts; in_valid held high in DONE leaves err_cnt unchanged.
- op=7, 4 vectors → err_cnt=4, pass=0.
- With GATE_CHK_TIMEOUT_EN and TIMEOUT=8: start, 1 accept, then in_valid=0 for 8 cycles → timeout=1, done=1, pass=0; then start → timeout=0, busy=1.
